vga_timing_monitor: RTL and testbench

- Receive-side counterpart of the VGA driver: consumes VGA_HS, VGA_VS and VGA_BLANK_N in the pixel-clock domain.
- Measures line and frame geometry, reconstructs active-pixel coordinates, and declares lock once timing matches the expected mode.
- Used in simulation and on-chip to check the driver and to feed a frame-capture/checker block.

---
 rtl/vga_timing_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: measures line/frame geometry, rebuilds
// active-pixel coordinates and tracks lock against an expected video mode.
module vga_timing_monitor #(
    parameter int EXP_H_TOTAL   = 800,
    parameter int EXP_V_TOTAL   = 525,
    parameter int LOCK_FRAMES   = 2,
    parameter bit HS_ACTIVE_LOW = 1'b1,
    parameter bit VS_ACTIVE_LOW = 1'b1,
    parameter int TIMEOUT       = 1600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic       vga_blank_n,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    output logic       px_valid,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic [9:0] h_active,
    output logic [9:0] v_active,
    output logic       locked,
    output logic       frame_done,
    output logic       sync_err
);
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [9:0]    EXP_H   = EXP_H_TOTAL[9:0];
    localparam logic [9:0]    EXP_V   = EXP_V_TOTAL[9:0];
    localparam logic [3:0]    LOCK_N  = LOCK_FRAMES[3:0];
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] a, input logic inc);
        return (a == 10'h3FF) ? a : a + {9'd0, inc};
    endfunction

    logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [9:0]    hcnt_q, hcnt_d, acnt_q, acnt_d;
    logic [9:0]    vcnt_q, vcnt_d, vact_cnt_q, vact_cnt_d;
    logic [9:0]    h_total_q, h_total_d, h_active_q, h_active_d;
    logic [9:0]    v_total_q, v_total_d, v_active_q, v_active_d;
    logic [9:0]    px_x_q, px_x_d, px_y_q, px_y_d, y_next_q, y_next_d;
    logic          px_valid_q, px_valid_d, frame_done_q, frame_done_d;
    logic          line_bad_q, line_bad_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    state_t        state_q;
    logic [3:0]    good_q;
    logic          locked_q, sync_err_q;

    logic          hs_act, vs_act, hs_rise, vs_rise;
    logic          line_active, line_len_bad, frame_len_bad, timeout_hit, first_px;
    logic [9:0]    h_len, v_len;

    assign hs_act        = vga_hs ^ HS_ACTIVE_LOW;
    assign vs_act        = vga_vs ^ VS_ACTIVE_LOW;
    assign hs_rise       = hs_act & ~hs_prev_q;
    assign vs_rise       = vs_act & ~vs_prev_q;
    assign h_len         = sat_inc(hcnt_q, 1'b1);
    assign v_len         = sat_inc(vcnt_q, hs_rise);
    assign line_active   = (acnt_q != 10'd0);
    assign line_len_bad  = hs_rise & (h_len != EXP_H);
    assign frame_len_bad = (v_len != EXP_V);
    assign timeout_hit   = ~hs_rise & (tcnt_q == TO_LAST);
    // acnt is cleared at each hsync start, so zero means no pixel yet this line
    assign first_px      = vga_blank_n & ~line_active;

    always_comb begin
        hs_prev_d    = hs_act;
        vs_prev_d    = vs_act;
        hcnt_d       = hs_rise ? 10'd0 : sat_inc(hcnt_q, 1'b1);
        acnt_d       = hs_rise ? 10'd0 : sat_inc(acnt_q, vga_blank_n);
        tcnt_d       = hs_rise ? '0 : ((tcnt_q == TO_MAX) ? tcnt_q : tcnt_q + TW'(1));
        h_total_d    = h_total_q;
        h_active_d   = h_active_q;
        v_total_d    = v_total_q;
        v_active_d   = v_active_q;
        vcnt_d       = sat_inc(vcnt_q, hs_rise);
        vact_cnt_d   = sat_inc(vact_cnt_q, hs_rise & line_active);
        line_bad_d   = line_bad_q | line_len_bad;
        y_next_d     = (hs_rise & line_active) ? y_next_q + 10'd1 : y_next_q;
        px_valid_d   = vga_blank_n;
        px_x_d       = px_x_q;
        px_y_d       = px_y_q;
        frame_done_d = vs_rise;

        if (hs_rise) begin
            h_total_d  = h_len;
            h_active_d = sat_inc(acnt_q, vga_blank_n);
        end
        // A coincident hsync start belongs to the frame that is ending
        if (vs_rise) begin
            v_total_d  = v_len;
            v_active_d = sat_inc(vact_cnt_q, hs_rise & line_active);
            vcnt_d     = 10'd0;
            vact_cnt_d = 10'd0;
            line_bad_d = 1'b0;
            y_next_d   = 10'd0;
        end
        if (first_px) begin
            px_x_d = 10'd0;
            px_y_d = y_next_q;
        end else if (vga_blank_n) begin
            px_x_d = px_x_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            hcnt_q       <= '0;
            acnt_q       <= '0;
            tcnt_q       <= '0;
            vcnt_q       <= '0;
            vact_cnt_q   <= '0;
            h_total_q    <= '0;
            h_active_q   <= '0;
            v_total_q    <= '0;
            v_active_q   <= '0;
            line_bad_q   <= 1'b0;
            y_next_q     <= '0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            px_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            hcnt_q       <= hcnt_d;
            acnt_q       <= acnt_d;
            tcnt_q       <= tcnt_d;
            vcnt_q       <= vcnt_d;
            vact_cnt_q   <= vact_cnt_d;
            h_total_q    <= h_total_d;
            h_active_q   <= h_active_d;
            v_total_q    <= v_total_d;
            v_active_q   <= v_active_d;
            line_bad_q   <= line_bad_d;
            y_next_q     <= y_next_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            px_valid_q   <= px_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Lock FSM; the partial frame seen right after SEARCH is never scored
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEARCH;
            good_q     <= 4'd0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;
            if (timeout_hit) begin
                state_q    <= SEARCH;
                good_q     <= 4'd0;
                locked_q   <= 1'b0;
                sync_err_q <= (state_q == LOCKED);
            end else begin
                case (state_q)
                    SEARCH: begin
                        if (vs_rise) begin
                            state_q <= ACQUIRE;
                            good_q  <= 4'd0;
                        end
                    end
                    ACQUIRE: begin
                        if (vs_rise) begin
                            if (frame_len_bad | line_bad_q | line_len_bad) begin
                                good_q <= 4'd0;
                            end else if (good_q + 4'd1 >= LOCK_N) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                good_q   <= LOCK_N;
                            end else begin
                                good_q <= good_q + 4'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (line_len_bad | (vs_rise & frame_len_bad)) begin
                            state_q    <= ACQUIRE;
                            good_q     <= 4'd0;
                            locked_q   <= 1'b0;
                            sync_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= SEARCH;
                        good_q   <= 4'd0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign px_valid   = px_valid_q;
    assign h_total    = h_total_q;
    assign v_total    = v_total_q;
    assign h_active   = h_active_q;
    assign v_active   = v_active_q;
    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor using a scaled 40x20 mode
// (32x16 active, 4-clock hsync, 2-line vsync) so many frames fit a short run.
module tb_vga_timing_monitor;
    localparam int H   = 40;
    localparam int HA  = 32;
    localparam int HS0 = 34;
    localparam int HSW = 4;
    localparam int VA  = 16;
    localparam int VS0 = 17;
    localparam int VSW = 2;

    logic       clk = 1'b0;
    logic       reset, vga_hs, vga_vs, vga_blank_n;
    logic [9:0] px_x, px_y, h_total, v_total, h_active, v_active;
    logic       px_valid, locked, frame_done, sync_err;

    always #5 clk = ~clk;

    vga_timing_monitor #(
        .EXP_H_TOTAL(40), .EXP_V_TOTAL(20), .LOCK_FRAMES(2),
        .HS_ACTIVE_LOW(1'b1), .VS_ACTIVE_LOW(1'b1), .TIMEOUT(100)
    ) dut (
        .clk(clk), .reset(reset), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
        .h_total(h_total), .v_total(v_total), .h_active(h_active), .v_active(v_active),
        .locked(locked), .frame_done(frame_done), .sync_err(sync_err)
    );

    typedef struct {int vtot; int vact; int htot; int lck; int pxx; int pxy;} frame_exp_t;
    typedef struct {int x; int y; int hact;} px_exp_t;

    frame_exp_t frame_q[$];
    px_exp_t    px_q[$];
    int         err_q[$];
    int         tests = 0;
    int         fails = 0;

    int y_idx, last_x, last_y;
    bit vs_prev;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " px_x"}, int'(px_x), 0);
        check({tag, " px_y"}, int'(px_y), 0);
        check({tag, " px_valid"}, int'(px_valid), 0);
        check({tag, " h_total"}, int'(h_total), 0);
        check({tag, " v_total"}, int'(v_total), 0);
        check({tag, " h_active"}, int'(h_active), 0);
        check({tag, " v_active"}, int'(v_active), 0);
        check({tag, " locked"}, int'(locked), 0);
        check({tag, " frame_done"}, int'(frame_done), 0);
        check({tag, " sync_err"}, int'(sync_err), 0);
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event
    initial begin
        frame_exp_t fe;
        px_exp_t    pe;
        int         eh;
        forever begin
            @(negedge clk);
            if (frame_done) begin
                if (frame_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_done: got unexpected pulse, expected none (t=%0t)", $time);
                end else begin
                    fe = frame_q.pop_front();
                    check("frame v_total", int'(v_total), fe.vtot);
                    check("frame v_active", int'(v_active), fe.vact);
                    check("frame h_total", int'(h_total), fe.htot);
                    check("frame locked", int'(locked), fe.lck);
                    check("frame px_valid", int'(px_valid), 0);
                    check("frame px_x held", int'(px_x), fe.pxx);
                    check("frame px_y held", int'(px_y), fe.pxy);
                end
            end
            if (sync_err) begin
                if (err_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sync_err: got unexpected pulse, expected none (t=%0t)", $time);
                end else begin
                    eh = err_q.pop_front();
                    check("sync_err h_total", int'(h_total), eh);
                    check("sync_err locked", int'(locked), 0);
                end
            end
            if (px_valid) begin
                if (px_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL px_valid: got unexpected active pixel, expected blanking (t=%0t)", $time);
                end else begin
                    pe = px_q.pop_front();
                    check("px_x", int'(px_x), pe.x);
                    check("px_y", int'(px_y), pe.y);
                    check("px h_active", int'(h_active), pe.hact);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        y_idx = 0; last_x = 0; last_y = 0; vs_prev = 1'b0;
    endtask

    // Drives one frame; pushes pixel expectations as pixels are issued and the
    // frame expectation on the cycle the vsync pulse starts.
    task automatic drive_frame(input int nlines, input bit coinc, input int stretch_v,
                               input int drop_lo, input int drop_hi, input int reset_v,
                               input int e_vtot, input int e_vact, input int e_htot,
                               input int e_lck);
        frame_exp_t fe;
        px_exp_t    pe;
        bit         hs_on, vs_on, blank, dropped;
        int         hlen;
        y_idx = 0;
        for (int v = 0; v < nlines; v++) begin
            hlen = (v == stretch_v) ? H + 1 : H;
            for (int h = 0; h < hlen; h++) begin
                @(negedge clk);
                if (v == reset_v && h == 11) check_zero("mid-frame reset");
                dropped = (v >= drop_lo) && (v <= drop_hi);
                hs_on   = !dropped && h >= HS0 && h < HS0 + HSW;
                if (coinc)
                    vs_on = (v == VS0 && h >= HS0) || (v > VS0 && v < VS0 + VSW) ||
                            (v == VS0 + VSW && h < HS0);
                else
                    vs_on = (v >= VS0) && (v < VS0 + VSW);
                blank = !dropped && v < VA && h < HA;
                if (v == reset_v && h == 10) begin
                    reset = 1'b1; last_x = 0; last_y = 0;
                end else begin
                    reset = 1'b0;
                end
                vga_hs = !hs_on; vga_vs = !vs_on; vga_blank_n = blank;
                if (blank) begin
                    pe.x = h; pe.y = y_idx; pe.hact = (v == 0) ? 0 : HA;
                    px_q.push_back(pe);
                    last_x = h; last_y = y_idx;
                    if (h == HA - 1) y_idx++;
                end
                if (vs_on && !vs_prev) begin
                    fe.vtot = e_vtot; fe.vact = e_vact; fe.htot = e_htot; fe.lck = e_lck;
                    fe.pxx = last_x; fe.pxy = last_y;
                    frame_q.push_back(fe);
                end
                vs_prev = vs_on;
            end
        end
    endtask

    initial begin
        reset = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
        do_reset();
        // Acquisition: first partial frame discarded, lock after 3rd vsync
        drive_frame(20, 0, -1, -1, -1, -1, 17, 16, 40, 0);
        drive_frame(20, 0, -1, -1, -1, -1, 20, 16, 40, 0);
        drive_frame(20, 0, -1, -1, -1, -1, 20, 16, 40, 1);
        drive_frame(20, 0, -1, -1, -1, -1, 20, 16, 40, 1);
        // One 41-clock line while locked
        err_q.push_back(41);
        drive_frame(20, 0, 8, -1, -1, -1, 20, 16, 40, 0);
        drive_frame(20, 0, -1, -1, -1, -1, 20, 16, 40, 0);
        drive_frame(20, 0, -1, -1, -1, -1, 20, 16, 40, 1);
        // hsync missing for lines 2..4 -> timeout while locked
        err_q.push_back(40);
        drive_frame(20, 0, -1, 2, 4, -1, 17, 13, 40, 0);
        drive_frame(20, 0, -1, -1, -1, -1, 20, 16, 40, 0);
        drive_frame(20, 0, -1, -1, -1, -1, 20, 16, 40, 1);
        // One-clock reset in vertical blanking while locked
        drive_frame(20, 0, -1, -1, -1, 16, 1, 0, 24, 0);
        drive_frame(20, 0, -1, -1, -1, -1, 20, 16, 40, 0);
        drive_frame(20, 0, -1, -1, -1, -1, 20, 16, 40, 1);
        // vsync start coincident with hsync start
        do_reset();
        drive_frame(20, 1, -1, -1, -1, -1, 18, 16, 40, 0);
        drive_frame(20, 1, -1, -1, -1, -1, 20, 16, 40, 0);
        drive_frame(20, 1, -1, -1, -1, -1, 20, 16, 40, 1);
        drive_frame(20, 1, -1, -1, -1, -1, 20, 16, 40, 1);
        // One line short per frame: never locks
        do_reset();
        drive_frame(19, 0, -1, -1, -1, -1, 17, 16, 40, 0);
        drive_frame(19, 0, -1, -1, -1, -1, 19, 16, 40, 0);
        drive_frame(19, 0, -1, -1, -1, -1, 19, 16, 40, 0);
        drive_frame(19, 0, -1, -1, -1, -1, 19, 16, 40, 0);
        repeat (4) @(negedge clk);
        check("frame_done events outstanding", frame_q.size(), 0);
        check("sync_err events outstanding", err_q.size(), 0);
        check("pixel events outstanding", px_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
